// File: rtl/pb_intr_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pb_intr_ctrl_pkg
// Shared definitions for the PicoBlaze interrupt controller: I/O port
// addresses, FSM state encoding and VECTOR register field positions.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pb_intr_ctrl_pkg;

  // PicoBlaze I/O port addresses owned by the controller
  localparam logic [7:0] PORT_STATUS = 8'h10;  // read-only: pending bits
  localparam logic [7:0] PORT_MASK   = 8'h11;  // read/write: enable mask
  localparam logic [7:0] PORT_CLEAR  = 8'h12;  // write-only: W1C / end of interrupt
  localparam logic [7:0] PORT_VECTOR = 8'h13;  // read-only: in-service vector

  // VECTOR register layout: {in_service, timeout, 3'b0, vector[2:0]}
  localparam int VEC_INSVC_BIT = 7;
  localparam int VEC_TMO_BIT   = 6;
  localparam int VEC_IDX_W     = 3;

  // Interrupt handshake sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pb_intr_ctrl_if.sv
// ---------------------------------------------------------------------------
// pb_intr_ctrl_if
// PicoBlaze port bus plus interrupt handshake, as seen by the controller.
// master = PicoBlaze side, slave = interrupt controller side.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pb_intr_ctrl_if;

  logic [7:0] port_id;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] out_port;
  logic [7:0] rd_data;
  logic       rd_hit;
  logic       interrupt;
  logic       interrupt_ack;

  modport master (
    output port_id, write_strobe, read_strobe, out_port, interrupt_ack,
    input  rd_data, rd_hit, interrupt
  );

  modport slave (
    input  port_id, write_strobe, read_strobe, out_port, interrupt_ack,
    output rd_data, rd_hit, interrupt
  );

endinterface

`default_nettype wire

// File: rtl/pb_prio_enc.sv
// ---------------------------------------------------------------------------
// pb_prio_enc
// Combinational lowest-index priority encoder: returns the index of the
// lowest set request bit and a valid flag (any bit set).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pb_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_req,
  output logic [2:0]   o_idx,
  output logic         o_valid
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    o_idx   = 3'd0;
    o_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = 3'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pb_intr_ctrl.sv
// ---------------------------------------------------------------------------
// pb_intr_ctrl
// PicoBlaze interrupt controller: rising-edge detect on up to 8 sources,
// pending/mask registers, single interrupt line and an
// assert/ack/service/end-of-interrupt sequencer.
// Optional macro PB_INTR_TIMEOUT_EN: ack timeout with sticky flag in
// VECTOR bit 6 (cleared by a read strobe to PORT_VECTOR).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pb_intr_ctrl
  import pb_intr_ctrl_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] irq_src,
  pb_intr_ctrl_if.slave      bus
);

  logic [NUM_SRC-1:0]   r_irq_q;
  logic [NUM_SRC-1:0]   r_pending;
  logic [NUM_SRC-1:0]   r_mask;
  logic                 r_in_service;
  logic [VEC_IDX_W-1:0] r_vector;
  state_t               r_state;
  state_t               w_state_nxt;

  logic [NUM_SRC-1:0]   w_rise;
  logic [NUM_SRC-1:0]   w_clr_bits;
  logic                 w_wr_mask;
  logic                 w_wr_clear;
  logic [VEC_IDX_W-1:0] w_enc_idx;
  logic                 w_active;
  logic                 w_interrupt;
  logic                 w_ack_take;
  logic                 w_eoi;
  logic                 w_tmo_expire;
  logic                 w_tmo_fire;
  logic                 w_tmo_flag;
  logic [7:0]           w_rd_data;
  logic                 w_rd_hit;

  assign w_wr_mask  = bus.write_strobe && (bus.port_id == PORT_MASK);
  assign w_wr_clear = bus.write_strobe && (bus.port_id == PORT_CLEAR);
  assign w_clr_bits = w_wr_clear ? bus.out_port[NUM_SRC-1:0] : '0;
  assign w_rise     = irq_src & ~r_irq_q;

  // Lowest enabled pending source; valid doubles as the "active" request
  pb_prio_enc #(
    .N (NUM_SRC)
  ) u_prio_enc (
    .i_req   (r_pending & r_mask),
    .o_idx   (w_enc_idx),
    .o_valid (w_active)
  );

  // Previous source levels for rising-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_irq_q <= '0;
    else          r_irq_q <= irq_src;
  end

  // Pending bits: W1C clear first, then new edges OR'd in so a set wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_pending <= '0;
    else          r_pending <= (r_pending & ~w_clr_bits) | w_rise;
  end

  // Software enable mask
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_mask <= '0;
    else if (w_wr_mask) r_mask <= bus.out_port[NUM_SRC-1:0];
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Sequencer next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_interrupt = 1'b0;
    w_ack_take  = 1'b0;
    w_eoi       = 1'b0;
    w_tmo_fire  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_active) w_state_nxt = ASSERT;
      end
      ASSERT: begin
        w_interrupt = 1'b1;
        if (!w_active) begin
          // request withdrawn by a mask or clear write before the ack
          w_state_nxt = IDLE;
        end else if (bus.interrupt_ack) begin
          w_ack_take  = 1'b1;
          w_state_nxt = SERVICE;
        end else if (w_tmo_expire) begin
          w_tmo_fire  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      SERVICE: begin
        // end of interrupt: clear write covering the in-service source
        if (w_wr_clear && bus.out_port[r_vector]) begin
          w_eoi       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // In-service flag and vector captured at the ack
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_service <= 1'b0;
      r_vector     <= '0;
    end else if (w_ack_take) begin
      r_in_service <= 1'b1;
      r_vector     <= w_enc_idx;
    end else if (w_eoi) begin
      r_in_service <= 1'b0;
    end
  end

`ifdef PB_INTR_TIMEOUT_EN
  logic [7:0] r_tmo_cnt;
  logic       r_tmo_flag;

  assign w_tmo_expire = (r_tmo_cnt == 8'(TIMEOUT_CYC - 1));
  assign w_tmo_flag   = r_tmo_flag;

  // Counts cycles spent in ASSERT; zero on entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               r_tmo_cnt <= '0;
    else if (r_state != ASSERT) r_tmo_cnt <= '0;
    else                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
  end

  // Sticky timeout flag; a new timeout beats a simultaneous read clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        r_tmo_flag <= 1'b0;
    else if (w_tmo_fire) r_tmo_flag <= 1'b1;
    else if (bus.read_strobe && (bus.port_id == PORT_VECTOR))
                         r_tmo_flag <= 1'b0;
  end
`else
  logic [1:0] w_unused_tmo;

  assign w_tmo_expire = 1'b0;
  assign w_tmo_flag   = 1'b0;
  assign w_unused_tmo = {bus.read_strobe, w_tmo_fire};
`endif

  // Combinational read mux on port_id
  always_comb begin
    w_rd_data = 8'h00;
    w_rd_hit  = 1'b0;
    case (bus.port_id)
      PORT_STATUS: begin
        w_rd_data[NUM_SRC-1:0] = r_pending;
        w_rd_hit               = 1'b1;
      end
      PORT_MASK: begin
        w_rd_data[NUM_SRC-1:0] = r_mask;
        w_rd_hit               = 1'b1;
      end
      PORT_VECTOR: begin
        w_rd_data[VEC_INSVC_BIT]   = r_in_service;
        w_rd_data[VEC_TMO_BIT]     = w_tmo_flag;
        w_rd_data[VEC_IDX_W-1:0]   = r_vector;
        w_rd_hit                   = 1'b1;
      end
      default: begin
        w_rd_data = 8'h00;
        w_rd_hit  = 1'b0;
      end
    endcase
  end

  assign bus.rd_data   = w_rd_data;
  assign bus.rd_hit    = w_rd_hit;
  assign bus.interrupt = w_interrupt;

endmodule

`default_nettype wire

// File: tb/tb_pb_intr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pb_intr_ctrl
// Self-checking bench for pb_intr_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural model of the controller.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pb_intr_ctrl;

  localparam int TMO = 4;
`ifdef PB_INTR_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] irq_src = 8'h00;

  pb_intr_ctrl_if bus();

  pb_intr_ctrl #(
    .NUM_SRC     (8),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .irq_src (irq_src),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [7:0] m_pend, m_mask, m_prev;
  logic       m_insvc, m_intr, m_tmo;
  logic [2:0] m_vec;
  int         m_acnt;

  function automatic void model_reset();
    m_pend = 8'h00; m_mask = 8'h00; m_prev = 8'h00;
    m_insvc = 1'b0; m_intr = 1'b0; m_tmo = 1'b0; m_vec = 3'd0; m_acnt = 0;
  endfunction

  // One clock of controller behaviour, using the inputs present at the edge
  function automatic void model_step();
    logic [7:0] en, clr, rise;
    int low;
    en   = m_pend & m_mask;
    clr  = (bus.write_strobe && bus.port_id == 8'h12) ? bus.out_port : 8'h00;
    rise = irq_src & ~m_prev;
    low  = 0;
    for (int i = 7; i >= 0; i--) if (en[i]) low = i;
    if (bus.read_strobe && bus.port_id == 8'h13) m_tmo = 1'b0;
    if (m_intr) begin
      if (en == 8'h00) m_intr = 1'b0;
      else if (bus.interrupt_ack) begin
        m_intr = 1'b0; m_insvc = 1'b1; m_vec = 3'(low);
      end else if (TMO_ON && m_acnt == TMO - 1) begin
        m_intr = 1'b0; m_tmo = 1'b1;
      end else m_acnt++;
    end else if (m_insvc) begin
      if (clr[m_vec]) m_insvc = 1'b0;
    end else if (en != 8'h00) begin
      m_intr = 1'b1; m_acnt = 0;
    end
    if (bus.write_strobe && bus.port_id == 8'h11) m_mask = bus.out_port;
    m_pend = (m_pend & ~clr) | rise;
    m_prev = irq_src;
  endfunction

  // Expected {rd_hit, rd_data} for a port address
  function automatic logic [8:0] exp_rd(input logic [7:0] pid);
    case (pid)
      8'h10:   return {1'b1, m_pend};
      8'h11:   return {1'b1, m_mask};
      8'h13:   return {1'b1, m_insvc, m_tmo, 3'b000, m_vec};
      default: return 9'h000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic bus_idle();
    bus.write_strobe = 1'b0; bus.read_strobe = 1'b0;
    bus.interrupt_ack = 1'b0; bus.out_port = 8'h00; bus.port_id = 8'h00;
  endtask

  task automatic wr(input logic [7:0] pid, input logic [7:0] data);
    bus.port_id = pid; bus.out_port = data; bus.write_strobe = 1'b1;
    tick();
    bus.write_strobe = 1'b0;
  endtask

  task automatic ack();
    bus.interrupt_ack = 1'b1;
    tick();
    bus.interrupt_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] pids [5];
    logic [8:0] want [5];
    pids = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h55};
    want = '{9'h100, 9'h100, 9'h000, 9'h100, 9'h000};
    bus_idle(); reset_n = 1'b0; model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.interrupt !== 1'b0) begin
      bad++; $display("FAIL reset_irq: got %b want 0", bus.interrupt);
    end
    for (int i = 0; i < 5; i++) begin
      bus.port_id = pids[i]; #1;
      total++;
      if ({bus.rd_hit, bus.rd_data} !== want[i]) begin
        bad++; $display("FAIL reset_rd port %h: got %h want %h", pids[i], {bus.rd_hit, bus.rd_data}, want[i]);
      end
    end
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_mask_gate();
    irq_src = 8'h04; tick(); irq_src = 8'h00; tick();
    bus.port_id = 8'h10; #1;
    total++;
    if (bus.rd_data !== 8'h04 || bus.interrupt !== 1'b0) begin
      bad++; $display("FAIL masked_pending: got %h/%b want 04/0", bus.rd_data, bus.interrupt);
    end
    wr(8'h11, 8'h04);
    total++;
    if (bus.interrupt !== 1'b0) begin
      bad++; $display("FAIL mask_irq_early: got %b want 0", bus.interrupt);
    end
    tick();
    total++;
    if (bus.interrupt !== 1'b1) begin
      bad++; $display("FAIL mask_irq_rise: got %b want 1", bus.interrupt);
    end
    ack();
    bus.port_id = 8'h13; #1;
    total++;
    if (bus.rd_data !== 8'h82 || bus.interrupt !== 1'b0) begin
      bad++; $display("FAIL mask_vec: got %h/%b want 82/0", bus.rd_data, bus.interrupt);
    end
    wr(8'h12, 8'h04);
  endtask

  task automatic test_vector();
    wr(8'h11, 8'hFF);
    irq_src = 8'h22; tick(); irq_src = 8'h00; tick();
    total++;
    if (bus.interrupt !== 1'b1) begin
      bad++; $display("FAIL vec_irq: got %b want 1", bus.interrupt);
    end
    ack();
    bus.port_id = 8'h13; #1;
    total++;
    if (bus.rd_data !== 8'h81 || bus.interrupt !== 1'b0) begin
      bad++; $display("FAIL vec_ack: got %h/%b want 81/0", bus.rd_data, bus.interrupt);
    end
    wr(8'h12, 8'h02);
    bus.port_id = 8'h13; #1;
    total++;
    if (bus.rd_data !== 8'h01 || bus.interrupt !== 1'b0) begin
      bad++; $display("FAIL vec_eoi: got %h/%b want 01/0", bus.rd_data, bus.interrupt);
    end
    tick();
    total++;
    if (bus.interrupt !== 1'b1) begin
      bad++; $display("FAIL vec_rearm: got %b want 1", bus.interrupt);
    end
    ack();
    bus.port_id = 8'h13; #1;
    total++;
    if (bus.rd_data !== 8'h85) begin
      bad++; $display("FAIL vec_second: got %h want 85", bus.rd_data);
    end
    wr(8'h12, 8'h20);
  endtask

  task automatic test_hold_level();
    wr(8'h11, 8'h00);
    irq_src = 8'h01;
    repeat (10) tick();
    bus.port_id = 8'h10; #1;
    total++;
    if (bus.rd_data !== 8'h01) begin
      bad++; $display("FAIL hold_single: got %h want 01", bus.rd_data);
    end
    wr(8'h12, 8'h01);
    repeat (3) tick();
    bus.port_id = 8'h10; #1;
    total++;
    if (bus.rd_data !== 8'h00) begin
      bad++; $display("FAIL hold_cleared: got %h want 00", bus.rd_data);
    end
    irq_src = 8'h00; tick();
  endtask

  task automatic test_set_wins();
    irq_src = 8'h08;
    wr(8'h12, 8'h08);
    bus.port_id = 8'h10; #1;
    total++;
    if (bus.rd_data !== 8'h08) begin
      bad++; $display("FAIL set_wins: got %h want 08", bus.rd_data);
    end
    irq_src = 8'h00;
    wr(8'h12, 8'h08);
  endtask

  task automatic test_reset_midservice();
    wr(8'h11, 8'hFF);
    irq_src = 8'h10; tick(); irq_src = 8'h00; tick();
    ack();
    bus.port_id = 8'h13; #1;
    total++;
    if (bus.rd_data !== 8'h84) begin
      bad++; $display("FAIL svc_vec: got %h want 84", bus.rd_data);
    end
    reset_n = 1'b0; model_reset(); #1;
    total++;
    if (bus.interrupt !== 1'b0 || bus.rd_data !== 8'h00) begin
      bad++; $display("FAIL async_vec: got %b/%h want 0/00", bus.interrupt, bus.rd_data);
    end
    bus.port_id = 8'h10; #1;
    total++;
    if (bus.rd_data !== 8'h00) begin
      bad++; $display("FAIL async_pend: got %h want 00", bus.rd_data);
    end
    bus.port_id = 8'h11; #1;
    total++;
    if (bus.rd_data !== 8'h00) begin
      bad++; $display("FAIL async_mask: got %h want 00", bus.rd_data);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    wr(8'h11, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (bus.interrupt !== 1'b0) begin
        bad++; $display("FAIL post_reset_irq cyc %0d: got %b want 0", i, bus.interrupt);
      end
    end
  endtask

  task automatic test_timeout();
    wr(8'h11, 8'hFF);
    irq_src = 8'h01; tick(); irq_src = 8'h00;
`ifdef PB_INTR_TIMEOUT_EN
    for (int i = 0; i < TMO; i++) begin
      tick();
      total++;
      if (bus.interrupt !== 1'b1) begin
        bad++; $display("FAIL tmo_held cyc %0d: got %b want 1", i, bus.interrupt);
      end
    end
    tick();
    bus.port_id = 8'h13; #1;
    total++;
    if (bus.interrupt !== 1'b0 || bus.rd_data !== 8'h40) begin
      bad++; $display("FAIL tmo_drop: got %b/%h want 0/40", bus.interrupt, bus.rd_data);
    end
    bus.read_strobe = 1'b1; tick(); bus.read_strobe = 1'b0;
    #1;
    total++;
    if (bus.rd_data[6] !== 1'b0 || bus.interrupt !== 1'b1) begin
      bad++; $display("FAIL tmo_rdclr: got %h/%b want bit6=0/1", bus.rd_data, bus.interrupt);
    end
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (bus.interrupt !== 1'b1) begin
        bad++; $display("FAIL no_tmo_held cyc %0d: got %b want 1", i, bus.interrupt);
      end
    end
    bus.port_id = 8'h13; #1;
    total++;
    if (bus.rd_data[6] !== 1'b0) begin
      bad++; $display("FAIL no_tmo_flag: got %h want bit6=0", bus.rd_data);
    end
`endif
    ack();
    wr(8'h12, 8'h01);
  endtask

  task automatic test_random();
    logic [8:0] e;
    for (int n = 0; n < 600; n++) begin
      irq_src = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 4))
        0:       bus.port_id = 8'h10;
        1:       bus.port_id = 8'h11;
        2:       bus.port_id = 8'h12;
        3:       bus.port_id = 8'h13;
        default: bus.port_id = 8'($urandom_range(0, 255));
      endcase
      bus.write_strobe  = ($urandom_range(0, 3) == 0);
      bus.read_strobe   = ($urandom_range(0, 3) == 0);
      bus.out_port      = 8'($urandom_range(0, 255));
      bus.interrupt_ack = ($urandom_range(0, 2) == 0);
      #1;
      e = exp_rd(bus.port_id);
      total++;
      if ({bus.rd_hit, bus.rd_data} !== e) begin
        bad++; $display("FAIL rand_rd n=%0d port %h: got %h want %h", n, bus.port_id, {bus.rd_hit, bus.rd_data}, e);
      end
      total++;
      if (bus.interrupt !== m_intr) begin
        bad++; $display("FAIL rand_irq n=%0d: got %b want %b", n, bus.interrupt, m_intr);
      end
      tick();
    end
    bus_idle();
    irq_src = 8'h00;
  endtask

  initial begin
    test_reset();
    test_mask_gate();
    test_vector();
    test_hold_level();
    test_set_wins();
    test_reset_midservice();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pb_intr_ctrl.md
Name: pb_intr_ctrl

Overview:
- Interrupt controller for the PicoBlaze core. It edge-detects up to eight peripheral interrupt sources (UART RX ready, TX empty, timer, etc.) and latches them as pending bits.
- It applies a software mask, drives the single PicoBlaze interrupt line and sequences the assert/ack/service/end-of-interrupt handshake.
- Sits beside the port strobe decoder on the port_id/strobe bus; it exposes status, mask, clear and vector registers as PicoBlaze I/O ports.

Parameters:
- NUM_SRC, 8, number of interrupt sources; legal range 1..8.
- PORT_STATUS, 8'h10, read-only port; returns pending bits.
- PORT_MASK, 8'h11, read/write port; enable mask, 1 = enabled.
- PORT_CLEAR, 8'h12, write-only port; write-1-to-clear pending bits / end of interrupt.
- PORT_VECTOR, 8'h13, read-only port; in-service vector.
- TIMEOUT_CYC, 255, ack timeout in clocks; used only with the optional feature.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- irq_src  in  NUM_SRC  peripheral requests; level or pulse, rising-edge sensitive.
- port_id  in  8  PicoBlaze port address.
- write_strobe  in  1  PicoBlaze write strobe.
- read_strobe  in  1  PicoBlaze read strobe; used only for the timeout clear.
- out_port  in  8  PicoBlaze write data.
- rd_data  out  8  read data for the top-level in_port mux.
- rd_hit  out  1  high when port_id matches any of this block's readable ports.
- interrupt  out  1  to PicoBlaze interrupt input.
- interrupt_ack  in  1  from PicoBlaze.

Behaviour:
- Reset (async, reset_n=0) clears all state:
  - pending=0, mask=0, in_service=0, vector=0, irq_q=0, state=IDLE, interrupt=0.
  - rd_data and rd_hit are combinational and therefore 0 unless port_id matches.
- Edge detect: irq_q registers irq_src. A bit is a rising edge when irq_src & ~irq_q. A rising edge sets the matching pending bit on the same clock edge.
- Writes:
  - write_strobe & port_id==PORT_MASK: mask <= out_port[NUM_SRC-1:0].
  - write_strobe & port_id==PORT_CLEAR: pending <= pending & ~out_port.
  - Set and clear of the same bit in the same cycle: set wins.
  - Writes to any other address are ignored.
- Reads (combinational on port_id):
  - PORT_STATUS returns pending, zero-extended.
  - PORT_MASK returns mask.
  - PORT_VECTOR returns {in_service, 4'b0, vector[2:0]}.
  - Any other address returns 8'h00 with rd_hit=0.
- active = |(pending & mask).
- FSM (2-bit state):
  - IDLE: interrupt=0. If active, go to ASSERT on the next clock; interrupt rises one cycle after the pending bit is set.
  - ASSERT: interrupt=1.
    - On interrupt_ack, latch vector = lowest-index set bit of (pending & mask), set in_service=1 and go to SERVICE. interrupt drops on the same edge.
    - If active falls before the ack (mask or clear write), return to IDLE with interrupt=0.
  - SERVICE: interrupt=0. A PORT_CLEAR write with bit[vector] set clears in_service and returns to IDLE. New edges keep pending but do not re-assert until IDLE.
- Re-arm: after the return to IDLE, remaining active bits re-assert interrupt after exactly 1 cycle.
- interrupt_ack outside ASSERT is ignored.
- NUM_SRC<8: unused out_port and irq bits are ignored; they read as 0.

Optional Feature:
- Macro: PB_INTR_TIMEOUT_EN.
- Defined:
  - An 8-bit counter runs in ASSERT.
  - If TIMEOUT_CYC cycles pass with no ack, go to IDLE, drop interrupt and set sticky timeout flag rd bit6 of PORT_VECTOR.
  - The flag clears on a read_strobe to PORT_VECTOR.
  - The pending bits are kept, so the request re-asserts the next cycle.
- Undefined: no counter; ASSERT waits indefinitely; bit6 reads 0.

Decomposition:
- Shared package (or include file pb_io_defs): port address constants PORT_STATUS/MASK/CLEAR/VECTOR, the FSM state encodings IDLE=2'd0 / ASSERT=2'd1 / SERVICE=2'd2, and the vector field positions.
- One natural sub-module: pb_prio_enc, a combinational lowest-index priority encoder (NUM_SRC in, 3-bit index plus valid out). It is reusable by other arbiters.

Test Plan:
- Reset then mask=8'h00: pulse irq_src[2] -> STATUS reads 8'h04, interrupt stays 0. Write MASK 8'h04 -> interrupt=1 one cycle later.
- mask=8'hFF, irq_src[5] and [1] rise together, then ack -> VECTOR reads 8'h81, interrupt=0. Write CLEAR 8'h02 -> VECTOR bit7=0, interrupt re-asserts after 1 cycle for source 5.
- Hold irq_src[0] high for 10 cycles -> single pending set. Write CLEAR 8'h01 while still high -> stays cleared, since there is no new edge.
- Same-cycle irq_src[3] rising edge and CLEAR 8'h08 -> pending[3]=1 (set wins).
- Assert reset_n=0 mid-SERVICE -> interrupt, pending, mask, VECTOR all 0 immediately (async). After release, no interrupt without a new edge.
- PB_INTR_TIMEOUT_EN with TIMEOUT_CYC=4, withhold ack -> interrupt drops after 4 cycles and VECTOR bit6=1. Read VECTOR -> bit6 cleared.
